// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared types, widths and count-to-value mapping for the bitstream dequantizer
//
// Purpose : default window geometry, FSM state type and the saturating
//           offset mapping from a window ones-count to a signed value.
// Contents: BITSTREAM_DEF, QUANT_DEF, CNT_W, D_SHIFT, state_t, count_to_data().

package bitstream_pkg;

  localparam int BITSTREAM_DEF = 64;
  localparam int QUANT_DEF     = 8;
  localparam int CNT_W         = $clog2(BITSTREAM_DEF) + 1;
  localparam int D_SHIFT       = QUANT_DEF - $clog2(BITSTREAM_DEF);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // value = (count << d) - 2^(quant-1); only the single top code (a full
  // window of ones) lands on +2^(quant-1), which is clipped to the max.
  function automatic int count_to_data(input int count, input int quant, input int d);
    int v;
    int half;
    half = 1 << (quant - 1);
    v    = (count << d) - half;
    if (v > half - 1) begin
      v = half - 1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bitstream_dequant_map.sv
// rtl/bitstream_dequant_map.sv - combinational ones-count to signed value mapper
//
// Purpose : maps a window ones-count onto the signed QUANT-bit datapath.
// Ports   : i_count - ones count, 0..BITSTREAM
//           o_data  - signed reconstructed value (saturated at the top end)

module bitstream_dequant_map
  import bitstream_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) (
  input  logic [$clog2(BITSTREAM):0] i_count,
  output logic [QUANT-1:0]           o_data
);

  localparam int D = QUANT - $clog2(BITSTREAM);

  assign o_data = QUANT'(count_to_data(int'(i_count), QUANT, D));

endmodule

// File: rtl/bitstream_dequota.sv
// rtl/bitstream_dequota.sv - unipolar bitstream window counter and signed value reconstructor
//
// Purpose : counts ones over each BITSTREAM-bit window of a serial stream and
//           presents the count plus the reconstructed signed value.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           in_valid/in_ready        - bit handshake; in_bit data, in_sof window start
//           out_valid/out_ready      - result handshake; out_count, out_data
//           sof_err                  - one-cycle pulse when in_sof truncated a window

module bitstream_dequota
  import bitstream_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bit,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(BITSTREAM):0] out_count,
  output logic [QUANT-1:0]           out_data,
  output logic                       sof_err
);

  localparam int               POS_W    = $clog2(BITSTREAM);
  localparam int               CW       = POS_W + 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BITSTREAM - 1);

  if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
    $error("bitstream_dequota: BITSTREAM must be a power of two and >= 2");
  end
  if (QUANT < $clog2(BITSTREAM)) begin : g_bad_quant
    $error("bitstream_dequota: QUANT must be >= $clog2(BITSTREAM)");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [POS_W-1:0] r_pos;
  logic [CW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic [QUANT-1:0] r_data;
  logic             r_valid;
  logic             r_sof_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_sof_restart;
  logic [POS_W-1:0] w_pos_eff;
  logic [CW-1:0]    w_acc_eff;
  logic [CW-1:0]    w_count;
  logic             w_last;
  logic [QUANT-1:0] w_mapped;

  // In HOLD the output slot is full, so a new bit may only enter in the cycle
  // the held result is being consumed.
  assign w_in_ready = !rst && ((r_state == ACCUM) || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // A mid-window sof restarts the window on this very bit.
  assign w_sof_restart = w_accept && in_sof && (r_pos != '0);
  assign w_pos_eff     = w_sof_restart ? '0 : r_pos;
  assign w_acc_eff     = w_sof_restart ? '0 : r_acc;
  assign w_count       = w_acc_eff + CW'(in_bit);
  assign w_last        = w_accept && (w_pos_eff == LAST_POS);

  bitstream_dequant_map #(
    .BITSTREAM (BITSTREAM),
    .QUANT     (QUANT)
  ) u_map (
    .i_count (w_count),
    .o_data  (w_mapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving HOLD never coincides with a window end: the bit accepted in that
  // cycle is position 0 and BITSTREAM >= 2.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: begin
        if (w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos     <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_sof_err <= w_sof_restart;

      if (w_accept) begin
        if (w_last) begin
          r_pos   <= '0;
          r_acc   <= '0;
          r_count <= w_count;
          r_data  <= w_mapped;
        end else begin
          r_pos <= w_pos_eff + 1'b1;
          r_acc <= w_count;
        end
      end

      if (w_last) begin
        r_valid <= 1'b1;
      end else if (r_state == HOLD && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_count = r_count;
  assign out_data  = r_data;
  assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_bitstream_dequota.sv
// tb/tb_bitstream_dequota.sv - self-checking bench for bitstream_dequota

module tb_bitstream_dequota;

  localparam int BS = 64;
  localparam int Q  = 8;
  localparam int D  = 2;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic [Q-1:0]  out_data;
  logic          sof_err;

  bitstream_dequota #(.BITSTREAM(BS), .QUANT(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_data  (out_data),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the bits of the window in progress, in arrival order
  bit mq[$];
  int exp_cnt[$];
  int exp_sof;

  int got_cnt[$];
  int got_dat[$];
  int got_cyc[$];
  int sof_cnt;
  int sof_wide;
  bit sof_prev = 1'b0;
  bit rand_rdy = 1'b0;
  int last_acc_cyc;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_cnt.push_back(int'(out_count));
      got_dat.push_back(int'($signed(out_data)));
      got_cyc.push_back(cyc);
    end
    if (sof_err) sof_cnt++;
    if (sof_err && sof_prev) sof_wide++;
    sof_prev = sof_err;
  end

  function automatic int exp_data(input int c);
    int v;
    v = c * (2 ** D) - 2 ** (Q - 1);
    if (v > 2 ** (Q - 1) - 1) v = 2 ** (Q - 1) - 1;
    return v;
  endfunction

  task automatic model_bit(input bit b, input bit sof);
    int s;
    if (sof && mq.size() != 0) begin
      mq.delete();
      exp_sof++;
    end
    mq.push_back(b);
    if (mq.size() == BS) begin
      s = 0;
      foreach (mq[i]) s += int'(mq[i]);
      exp_cnt.push_back(s);
      mq.delete();
    end
  endtask

  task automatic clear_logs();
    got_cnt.delete();
    got_dat.delete();
    got_cyc.delete();
    exp_cnt.delete();
    exp_sof  = 0;
    sof_cnt  = 0;
    sof_wide = 0;
  endtask

  task automatic build(input int ones, output bit w[BS]);
    bit t;
    int j;
    for (int i = 0; i < BS; i++) w[i] = (i < ones);
    for (int i = BS - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = w[i]; w[i] = w[j]; w[j] = t;
    end
  endtask

  task automatic send_bit(input bit b, input bit sof, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      if (!ok && rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (ok) model_bit(b, sof);
    else begin
      n_tests++; n_fail++;
      $display("FAIL send_bit_timeout: in_ready=0 for 200 cycles, required 1");
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_results();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rand_rdy = 1'b0;
    for (int k = 0; k < 400 && got_cnt.size() < exp_cnt.size(); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_sof = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_tests++; if (sof_err !== 1'b0) begin n_fail++; $display("FAIL reset_sof_err: got %0b want 0", sof_err); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    mq.delete();
  endtask

  task automatic test_all_ones();
    int acc_cyc;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < BS; i++) send_bit(1'b1, 1'b0, 0);
    acc_cyc = last_acc_cyc;
    wait_results();
    n_tests++;
    if (got_cnt.size() !== 1) begin n_fail++; $display("FAIL ones_nres: got %0d want 1", got_cnt.size()); end
    else begin
      n_tests++; if (got_cnt[0] !== 64) begin n_fail++; $display("FAIL ones_count: got %0d want 64", got_cnt[0]); end
      n_tests++; if (got_dat[0] !== 127) begin n_fail++; $display("FAIL ones_data: got %0d want 127", got_dat[0]); end
      n_tests++; if (got_cyc[0] !== acc_cyc + 1) begin n_fail++; $display("FAIL ones_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc + 1); end
    end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_valid_drop: got %0b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_patterns();
    int wc[2] = '{32, 0};
    int wd[2] = '{0, -128};
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < BS; i++) send_bit(1'((i + 1) % 2), 1'b0, 0);
    for (int i = 0; i < BS; i++) send_bit(1'b0, 1'b0, 0);
    wait_results();
    n_tests++;
    if (got_cnt.size() !== 2) begin n_fail++; $display("FAIL pat_nres: got %0d want 2", got_cnt.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_tests++; if (got_cnt[i] !== wc[i]) begin n_fail++; $display("FAIL pat_count[%0d]: got %0d want %0d", i, got_cnt[i], wc[i]); end
      n_tests++; if (got_dat[i] !== wd[i]) begin n_fail++; $display("FAIL pat_data[%0d]: got %0d want %0d", i, got_dat[i], wd[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit w[BS];
    bit b;
    clear_logs();
    build(17, w);
    out_ready = 1'b0;
    for (int i = 0; i < BS; i++) send_bit(w[i], 1'b0, $urandom_range(0, 2));
    in_valid = 1'b1; in_bit = 1'b1; in_sof = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, out_valid); end
      n_tests++; if (out_count !== 7'd17) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d want 17", k, out_count); end
      n_tests++; if ($signed(out_data) !== -8'sd60) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want -60", k, $signed(out_data)); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0, 0);
    for (int i = 1; i < BS; i++) begin
      b = 1'($urandom_range(0, 1));
      send_bit(b, 1'b0, $urandom_range(0, 1));
    end
    wait_results();
    n_tests++;
    if (got_cnt.size() !== 2 || exp_cnt.size() !== 2) begin n_fail++; $display("FAIL bp_nres: got %0d want 2", got_cnt.size()); end
    else begin
      n_tests++; if (got_cnt[0] !== 17 || got_dat[0] !== -60) begin n_fail++; $display("FAIL bp_release: got %0d/%0d want 17/-60", got_cnt[0], got_dat[0]); end
      n_tests++; if (got_cnt[1] !== exp_cnt[1]) begin n_fail++; $display("FAIL bp_next_count: got %0d want %0d", got_cnt[1], exp_cnt[1]); end
      n_tests++; if (got_dat[1] !== exp_data(exp_cnt[1])) begin n_fail++; $display("FAIL bp_next_data: got %0d want %0d", got_dat[1], exp_data(exp_cnt[1])); end
    end
  endtask

  task automatic test_sof();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0, 0);
    send_bit(1'($urandom_range(0, 1)), 1'b1, 0);
    for (int i = 1; i < BS; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 1));
    wait_results();
    n_tests++; if (sof_cnt !== 1) begin n_fail++; $display("FAIL sof_pulses: got %0d want 1", sof_cnt); end
    n_tests++; if (sof_wide !== 0) begin n_fail++; $display("FAIL sof_width: got %0d extra cycles want 0", sof_wide); end
    n_tests++;
    if (got_cnt.size() !== 1 || exp_cnt.size() !== 1) begin n_fail++; $display("FAIL sof_nres: got %0d want 1", got_cnt.size()); end
    else begin
      n_tests++; if (got_cnt[0] !== exp_cnt[0]) begin n_fail++; $display("FAIL sof_count: got %0d want %0d", got_cnt[0], exp_cnt[0]); end
      n_tests++; if (got_dat[0] !== exp_data(exp_cnt[0])) begin n_fail++; $display("FAIL sof_data: got %0d want %0d", got_dat[0], exp_data(exp_cnt[0])); end
    end
  endtask

  task automatic test_back_to_back();
    int ones[3] = '{10, 40, 64};
    int wd[3]   = '{-88, 32, 127};
    bit w[BS];
    int first_acc;
    clear_logs();
    out_ready = 1'b1;
    first_acc = -1;
    for (int n = 0; n < 3; n++) begin
      build(ones[n], w);
      for (int i = 0; i < BS; i++) begin
        send_bit(w[i], i == 0, 0);
        if (first_acc < 0) first_acc = last_acc_cyc;
      end
    end
    n_tests++; if (last_acc_cyc - first_acc !== 3 * BS - 1) begin n_fail++; $display("FAIL b2b_span: got %0d cycles want %0d", last_acc_cyc - first_acc, 3 * BS - 1); end
    wait_results();
    n_tests++; if (sof_cnt !== 0) begin n_fail++; $display("FAIL b2b_sof_err: got %0d want 0", sof_cnt); end
    n_tests++;
    if (got_cnt.size() !== 3) begin n_fail++; $display("FAIL b2b_nres: got %0d want 3", got_cnt.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_tests++; if (got_cnt[i] !== ones[i]) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, got_cnt[i], ones[i]); end
      n_tests++; if (got_dat[i] !== wd[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got_dat[i], wd[i]); end
      if (i > 0) begin
        n_tests++; if (got_cyc[i] - got_cyc[i-1] !== BS) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, got_cyc[i] - got_cyc[i-1], BS); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit w[BS];
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    build(8, w);
    for (int i = 0; i < BS; i++) send_bit(w[i], 1'b0, $urandom_range(0, 1));
    wait_results();
    n_tests++;
    if (got_cnt.size() !== 1) begin n_fail++; $display("FAIL rstmid_nres: got %0d want 1", got_cnt.size()); end
    else begin
      n_tests++; if (got_cnt[0] !== 8) begin n_fail++; $display("FAIL rstmid_count: got %0d want 8", got_cnt[0]); end
      n_tests++; if (got_dat[0] !== -96) begin n_fail++; $display("FAIL rstmid_data: got %0d want -96", got_dat[0]); end
    end
  endtask

  task automatic test_random();
    clear_logs();
    rand_rdy = 1'b1;
    for (int i = 0; i < 6 * BS; i++)
      send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
    // complete any partial window so every accepted bit is accounted for
    while (mq.size() != 0) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
    wait_results();
    n_tests++; if (sof_cnt !== exp_sof) begin n_fail++; $display("FAIL rnd_sof: got %0d want %0d", sof_cnt, exp_sof); end
    n_tests++; if (sof_wide !== 0) begin n_fail++; $display("FAIL rnd_sof_width: got %0d want 0", sof_wide); end
    n_tests++;
    if (got_cnt.size() !== exp_cnt.size()) begin n_fail++; $display("FAIL rnd_nres: got %0d want %0d", got_cnt.size(), exp_cnt.size()); end
    else foreach (exp_cnt[i]) begin
      n_tests++; if (got_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, got_cnt[i], exp_cnt[i]); end
      n_tests++; if (got_dat[i] !== exp_data(exp_cnt[i])) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0d want %0d", i, got_dat[i], exp_data(exp_cnt[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_patterns();
    test_backpressure();
    test_sof();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
